// File: rtl/noc_pkg.sv
// Shared flit type encodings and arbiter state type for the flit
// arbitration mux.
package noc_pkg;

   localparam logic [1:0] TYPE_NONE = 2'b00;
   localparam logic [1:0] TYPE_HEAD = 2'b01;
   localparam logic [1:0] TYPE_DATA = 2'b10;
   localparam logic [1:0] TYPE_TAIL = 2'b11;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority pick: the search starts one past rr_ptr and wraps,
// so the last winner has the lowest priority.
module rr_arbiter #(
   parameter int NPORT = 4,
   parameter int PW    = 2
) (
   input  logic [NPORT-1:0] req,
   input  logic [PW-1:0]    rr_ptr,
   output logic [NPORT-1:0] grant
);

   logic          found;
   logic [PW-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned off = 1; off <= NPORT; off++) begin
         idx = PW'((32'(rr_ptr) + off) % NPORT);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/flit_arb_mux.sv
// Packet-atomic N:1 flit mux: round-robin grant on HEAD, lock to the owner
// until TAIL, orphan-flit discard, and a static-select bypass mode.
module flit_arb_mux
   import noc_pkg::*;
#(
   parameter int NPORT = 4,
   parameter int DATAW = 66,
   parameter int VCHW  = 2,
   parameter int SELW  = (NPORT > 1) ? $clog2(NPORT) : 1
) (
   input  logic                   clk,
   input  logic                   rst_,
   input  logic [NPORT*DATAW-1:0] idata,
   input  logic [NPORT-1:0]       ivalid,
   input  logic [NPORT*VCHW-1:0]  ivch,
   output logic [NPORT-1:0]       iready,
   output logic [DATAW-1:0]       odata,
   output logic                   ovalid,
   output logic [VCHW-1:0]        ovch,
   input  logic                   oready,
   input  logic                   force_en,
   input  logic [SELW-1:0]        force_sel,
   output logic                   drop_err
);

   logic [DATAW-1:0] in_data [NPORT];
   logic [VCHW-1:0]  in_vch  [NPORT];
   logic [1:0]       in_type [NPORT];
   logic [NPORT-1:0] head_req;
   logic [NPORT-1:0] orphan_req;
   logic [NPORT-1:0] none_req;
   logic [NPORT-1:0] grant;

   arb_state_e       state_q, state_d;
   logic [SELW-1:0]  owner_q, owner_d;
   logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [DATAW-1:0] odata_q, odata_d;
   logic [VCHW-1:0]  ovch_q, ovch_d;
   logic             ovalid_q, ovalid_d;
   logic             drop_err_q, drop_err_d;
   logic             armed_q, armed_d;

   logic             load_ok;
   logic             load;
   logic [SELW-1:0]  sel;
   logic [SELW-1:0]  win_idx;
   logic [SELW-1:0]  orphan_idx;

   for (genvar g = 0; g < NPORT; g++) begin : g_unpack
      assign in_data[g]    = idata[g*DATAW +: DATAW];
      assign in_vch[g]     = ivch[g*VCHW +: VCHW];
      assign in_type[g]    = in_data[g][DATAW-1:DATAW-2];
      assign head_req[g]   = ivalid[g] && (in_type[g] == TYPE_HEAD);
      assign none_req[g]   = ivalid[g] && (in_type[g] == TYPE_NONE);
      assign orphan_req[g] = ivalid[g] &&
                             ((in_type[g] == TYPE_DATA) || (in_type[g] == TYPE_TAIL));
   end

   rr_arbiter #(
      .NPORT (NPORT),
      .PW    (SELW)
   ) u_rr_arbiter (
      .req    (head_req),
      .rr_ptr (rr_ptr_q),
      .grant  (grant)
   );

   always_comb begin
      win_idx    = '0;
      orphan_idx = '0;
      for (int unsigned p = 0; p < NPORT; p++) begin
         if (grant[p]) win_idx = SELW'(p);
      end
      // Descending scan so the lowest-numbered orphan port ends up selected.
      for (int unsigned p = NPORT; p > 0; p--) begin
         if (orphan_req[p-1]) orphan_idx = SELW'(p-1);
      end
   end

   assign load_ok = !ovalid_q || oready;
   assign armed_d = 1'b1;

   // armed_q keeps every iready low during the first cycle out of reset.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      iready     = '0;
      load       = 1'b0;
      sel        = owner_q;
      drop_err_d = 1'b0;
      if (armed_q) begin
         if ((state_q == ST_IDLE) && force_en) begin
            sel               = force_sel;
            iready[force_sel] = load_ok;
            load              = ivalid[force_sel] && load_ok;
         end else if (state_q == ST_IDLE) begin
            for (int unsigned p = 0; p < NPORT; p++) begin
               if (none_req[p]) iready[p] = load_ok;
            end
            if (|head_req) begin
               sel             = win_idx;
               iready[win_idx] = load_ok;
               if (load_ok) begin
                  load     = 1'b1;
                  state_d  = ST_LOCKED;
                  owner_d  = win_idx;
                  rr_ptr_d = win_idx;
               end
            end else if (|orphan_req) begin
               iready[orphan_idx] = load_ok;
               drop_err_d         = load_ok;
            end
         end else begin
            iready[owner_q] = load_ok;
            if (ivalid[owner_q] && load_ok) begin
               load = (in_type[owner_q] != TYPE_NONE);
               if (in_type[owner_q] == TYPE_TAIL) state_d = ST_IDLE;
            end
         end
      end
   end

   always_comb begin
      odata_d  = odata_q;
      ovch_d   = ovch_q;
      ovalid_d = ovalid_q && !oready;
      if (load) begin
         odata_d  = in_data[sel];
         ovch_d   = in_vch[sel];
         ovalid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q    <= ST_IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= SELW'(NPORT - 1);
         odata_q    <= '0;
         ovch_q     <= '0;
         ovalid_q   <= 1'b0;
         drop_err_q <= 1'b0;
         armed_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         odata_q    <= odata_d;
         ovch_q     <= ovch_d;
         ovalid_q   <= ovalid_d;
         drop_err_q <= drop_err_d;
         armed_q    <= armed_d;
      end
   end

   assign odata    = odata_q;
   assign ovch     = ovch_q;
   assign ovalid   = ovalid_q;
   assign drop_err = drop_err_q;

endmodule

// File: doc/flit_arb_mux.md
FLIT_ARB_MUX -- requirements
Module: flit_arb_mux

Interface
REQ-001 The block SHALL have parameter NPORT, default 4, giving the number of input ports (2..8).
REQ-002 The block SHALL have parameter DATAW, default 66, giving the flit width; bits [DATAW-1:DATAW-2] carry the flit type.
REQ-003 The block SHALL have parameter VCHW, default 2, giving the virtual-channel tag width.
REQ-004 The block SHALL have input clk, 1 bit, the single clock; all flops are rising-edge.
REQ-005 The block SHALL have input rst_, 1 bit, the reset: asynchronous, active-low.
REQ-006 The block SHALL have input idata, NPORT*DATAW bits, input flits with port p in slice p.
REQ-007 The block SHALL have input ivalid, NPORT bits, per-port flit valid.
REQ-008 The block SHALL have input ivch, NPORT*VCHW bits, per-port VC tag.
REQ-009 The block SHALL have output iready, NPORT bits, per-port accept.
REQ-010 The block SHALL have output odata, DATAW bits, the registered output flit.
REQ-011 The block SHALL have output ovalid, 1 bit, output flit valid.
REQ-012 The block SHALL have output ovch, VCHW bits, output VC tag.
REQ-013 The block SHALL have input oready, 1 bit, downstream accept.
REQ-014 The block SHALL have input force_en, 1 bit; when high, arbitration is bypassed in static-select mode.
REQ-015 The block SHALL have input force_sel, clog2(NPORT) bits, the port used in static-select mode.
REQ-016 The block SHALL have output drop_err, 1 bit, a one-cycle pulse flagging a discarded orphan flit.

Function
REQ-017 A transfer SHALL occur on port p when ivalid[p] and iready[p] are both high at a clk edge; the output transfers when ovalid and oready are both high.
REQ-018 The output register SHALL be loadable when ovalid=0 or oready=1; iready[p] SHALL be low whenever the register is not loadable.
REQ-019 Latency SHALL be exactly 1 cycle from input transfer to ovalid; with oready held high, throughput SHALL be 1 flit/cycle.
REQ-020 The FSM SHALL have states IDLE and LOCKED, and reset SHALL enter IDLE.
REQ-021 In IDLE, among ports presenting valid HEAD flits, the round-robin winner SHALL be chosen starting at (rr_ptr+1) mod NPORT.
REQ-022 On the winner's HEAD transfer, the FSM SHALL go to LOCKED with owner=winner, and rr_ptr SHALL be set to the winner.
REQ-023 In LOCKED, only iready[owner] SHALL be asserted; every other port SHALL be held (iready low).
REQ-024 On the owner's TAIL transfer, the FSM SHALL return to IDLE; the next packet SHALL be grantable the following cycle.
REQ-025 In IDLE, a valid non-HEAD flit on a port with no valid HEAD anywhere SHALL be accepted and discarded: not loaded, drop_err pulsed, lowest such port first.
REQ-026 A second HEAD arriving from the owner while LOCKED SHALL be forwarded unchanged (no re-arbitration).
REQ-027 TYPE_NONE flits with ivalid high SHALL be accepted and discarded without drop_err.
REQ-028 When force_en=1, iready SHALL be asserted only for port force_sel, the FSM and rr_ptr SHALL freeze, and flits SHALL pass regardless of type.
REQ-029 A force_en change SHALL take effect only while the FSM is IDLE; while LOCKED, it SHALL be deferred until after TAIL.
REQ-030 ovch SHALL be registered together with odata, from the same port and in the same cycle.

Reset
REQ-031 While rst_ is low, the block SHALL hold ovalid=0, odata=0, ovch=0, drop_err=0, iready=0, FSM=IDLE, rr_ptr=NPORT-1, owner=0.
REQ-032 Reset asserted mid-packet SHALL abandon the packet, and no partial packet SHALL be emitted after release.
REQ-033 iready SHALL stay low in the first cycle after rst_ deasserts.

Structure
REQ-034 Package noc_pkg SHALL hold TYPE_NONE=2'b00, TYPE_HEAD=2'b01, TYPE_DATA=2'b10, TYPE_TAIL=2'b11, and the FSM state enum.
REQ-035 The round-robin priority pick SHALL be a sub-module rr_arbiter (NPORT request bits in, one-hot grant out, rr_ptr in).
REQ-036 The output register, FSM and drop logic SHALL stay in flit_arb_mux.

Verification
REQ-037 The bench SHALL check: HEAD on ports 1 and 3 in the same cycle after reset -> port 1 wins (rr_ptr=3), its 22 flits appear consecutively, then port 3 is granted the cycle after TAIL.
REQ-038 The bench SHALL check: port 2 sends a 20-DATA packet while port 0 holds a HEAD -> iready[0]=0 until 1 cycle after port 2's TAIL, with no interleaving on odata.
REQ-039 The bench SHALL check: oready toggled 0/1 every cycle mid-packet -> no flit is lost or duplicated, odata is stable while ovalid=1 and oready=0, and packet order is preserved.
REQ-040 The bench SHALL check: DATA flit 0x2_00000000_00000005 on port 0 in IDLE -> drop_err pulses 1 cycle, ovalid stays 0.
REQ-041 The bench SHALL check: force_en=1, force_sel=1, ports 0 and 1 both valid -> only port 1 flits appear, iready[0]=0.
REQ-042 The bench SHALL check: rst_ pulled low after the 5th DATA flit -> ovalid=0 immediately; after release, a fresh HEAD is arbitrated normally and the remaining old flits are dropped as orphans.
